// File: rtl/param_alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// produce a result one cycle after acceptance; MUL runs a WIDTH-cycle shift-add.
module param_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_cout;
    logic                 alu_ovf;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign sum_ext  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
    assign diff     = A - B;
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle datapath; MUL is handled by the shift-add sequencer below.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_SUB: begin
                alu_res  = diff;
                alu_cout = (A >= B);
                alu_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
                alu_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_OR:   alu_res = A | B;
            OP_AND:  alu_res = A & B;
            OP_XOR:  alu_res = A ^ B;
            OP_SHL: begin
                alu_res  = {A[WIDTH-2:0], 1'b0};
                alu_cout = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_res  = {1'b0, A[WIDTH-1:1]};
                alu_cout = A[0];
            end
            default: ;
        endcase
    end

    // Control FSM; reset beats every handshake and aborts a multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res       <= '0;
            cout      <= 1'b0;
            zero      <= 1'b1;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            case (state)
                MUL_RUN: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        res       <= acc_step[WIDTH-1:0];
                        cout      <= |acc_step[2*WIDTH-1:WIDTH];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                        neg       <= acc_step[WIDTH-1];
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state     <= MUL_RUN;
                            out_valid <= 1'b0;
                            mcand     <= {{WIDTH{1'b0}}, A};
                            mplier    <= B;
                            acc       <= '0;
                            count     <= '0;
                        end else begin
                            state     <= DONE;
                            res       <= alu_res;
                            cout      <= alu_cout;
                            zero      <= (alu_res == '0);
                            neg       <= alu_res[WIDTH-1];
                            ovf       <= alu_ovf;
                            out_valid <= 1'b1;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
